// File: rtl/fifo_rd_streamer.sv
// Read-side controller for the cyclic FIFO: prefetches into a 2-entry skid buffer and
// presents a valid/ready stream with burst markers. FIFO_RD_STALL_CNT_EN adds stall_cnt.
module fifo_rd_streamer #(
  parameter int unsigned DATA      = 8,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            fifo_empty,
  input  logic            fifo_uf,
  input  logic [DATA-1:0] read_data,
  input  logic            read_data_valid,
  output logic            read_req,
  output logic [DATA-1:0] m_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic            m_last,
  output logic            busy,
  output logic            err
`ifdef FIFO_RD_STALL_CNT_EN
  ,
  output logic [15:0]     stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [DATA-1:0] buf_mem [0:1];
  logic            head;
  logic            tail;
  logic [1:0]      buf_cnt;
  logic            inflight;
  logic [7:0]      burst_cnt;
  logic            rst_settle;
  logic            pop;
  logic            push;
  logic            last_word;
  logic [2:0]      occ;

  assign pop       = m_valid & m_ready;
  assign tail      = head ^ buf_cnt[0];
  assign last_word = (burst_cnt == 8'(BURST_LEN - 1));

  // Occupancy after this cycle's pop, counting the word still in flight from the FIFO.
  assign occ      = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign read_req = (state == ACTIVE) && !fifo_empty && (occ < 3'd2);

  // Stray strobes (first cycle after reset, or into a full buffer) are not stored.
  assign push = read_data_valid && !rst_settle && ((buf_cnt != 2'd2) || pop);

  assign m_valid = (buf_cnt != 2'd0);
  assign m_data  = m_valid ? buf_mem[head] : '0;
  assign m_last  = m_valid && last_word;
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (enable) state_nxt = ACTIVE;
      ACTIVE:  if (!enable) state_nxt = DRAIN;
      DRAIN:   if (!inflight && (buf_cnt == 2'd0)) state_nxt = enable ? ACTIVE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
      head       <= 1'b0;
      buf_cnt    <= '0;
      inflight   <= 1'b0;
      burst_cnt  <= '0;
      err        <= 1'b0;
      rst_settle <= 1'b1;
    end else begin
      state      <= state_nxt;
      inflight   <= read_req;
      rst_settle <= 1'b0;
      if (push) buf_mem[tail] <= read_data;
      if (pop) head <= ~head;
      if (push && !pop) buf_cnt <= buf_cnt + 2'd1;
      else if (pop && !push) buf_cnt <= buf_cnt - 2'd1;
      if (pop) burst_cnt <= last_word ? '0 : burst_cnt + 8'd1;
      if (fifo_uf || (read_data_valid && !inflight && !rst_settle)) err <= 1'b1;
    end
  end

`ifdef FIFO_RD_STALL_CNT_EN
  logic enable_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enable_q  <= 1'b0;
      stall_cnt <= '0;
    end else begin
      enable_q <= enable;
      if (enable && !enable_q) stall_cnt <= '0;
      else if (m_valid && !m_ready && (stall_cnt != '1)) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Scoreboard bench for fifo_rd_streamer with a behavioural 1-cycle-latency FIFO model.
module tb_fifo_rd_streamer;
  localparam int unsigned DATA      = 8;
  localparam int unsigned BURST_LEN = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, enable, fifo_empty, read_data_valid, read_req;
  logic       m_valid, m_ready, m_last, busy, err;
  logic [7:0] read_data, m_data;
`ifdef FIFO_RD_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  // FIFO model: tasks own wp and fmem, the model process owns rp.
  logic [7:0] fmem [0:255];
  logic [7:0] wp;
  logic [7:0] rp      = 8'd0;
  logic       fm_rdv  = 1'b0;
  logic [7:0] fm_data = 8'd0;
  logic       fifo_uf = 1'b0;
  logic       flush;
  logic       inj_rdv;
  logic [7:0] inj_data;

  assign fifo_empty      = (wp == rp);
  assign read_data_valid = fm_rdv | inj_rdv;
  assign read_data       = inj_rdv ? inj_data : fm_data;

  always @(posedge clk) begin
    fm_rdv  <= 1'b0;
    fifo_uf <= 1'b0;
    if (flush) rp <= wp;
    else if (read_req) begin
      if (wp == rp) fifo_uf <= 1'b1;
      else begin
        fm_data <= fmem[rp];
        fm_rdv  <= 1'b1;
        rp      <= rp + 8'd1;
      end
    end
  end

  fifo_rd_streamer #(.DATA(DATA), .BURST_LEN(BURST_LEN)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty), .fifo_uf(fifo_uf),
    .read_data(read_data), .read_data_valid(read_data_valid), .read_req(read_req),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy), .err(err)
`ifdef FIFO_RD_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  logic [8:0]  sb [$];
  int unsigned sb_idx = 0;

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic fifo_put(input logic [7:0] w);
    fmem[wp] = w;
    wp = wp + 8'd1;
  endtask

  task automatic sb_put(input logic [7:0] w);
    sb.push_back({(sb_idx == BURST_LEN - 1), w});
    sb_idx = (sb_idx + 1) % BURST_LEN;
  endtask

  task automatic apply_reset();
    rst = 1'b0; enable = 1'b0; m_ready = 1'b0; inj_rdv = 1'b0; flush = 1'b1;
    next_edge();
    next_edge();
    flush = 1'b0;
    sb.delete();
    sb_idx = 0;
    rst = 1'b1;
    next_edge();
  endtask

  task automatic test_reset();
    next_edge();
    next_edge();
    checks++; if (read_req !== 1'b0) begin errors++; $display("FAIL reset_read_req got %b exp 0", read_req); end
    checks++; if (m_valid !== 1'b0)  begin errors++; $display("FAIL reset_m_valid got %b exp 0", m_valid); end
    checks++; if (m_last !== 1'b0)   begin errors++; $display("FAIL reset_m_last got %b exp 0", m_last); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (err !== 1'b0)      begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    checks++; if (m_data !== 8'h00)  begin errors++; $display("FAIL reset_m_data got %h exp 00", m_data); end
    flush = 1'b0;
    rst = 1'b1;
    next_edge();
    next_edge();
    checks++; if (busy !== 1'b0 || m_valid !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset got busy=%b m_valid=%b exp 0 0", busy, m_valid);
    end
  endtask

  task automatic test_first_words();
    int first_rr = -1, last_rr = -1, n_rr = 0, first_pop = -1, last_pop = -1, n_pop = 0, bad_rr = 0;
    logic [8:0] exp;
    apply_reset();
    fifo_put(8'h11); sb_put(8'h11);
    fifo_put(8'h22); sb_put(8'h22);
    fifo_put(8'h33); sb_put(8'h33);
    m_ready = 1'b1; enable = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (read_req && fifo_empty) bad_rr++;
      if (read_req) begin if (first_rr < 0) first_rr = c; last_rr = c; n_rr++; end
      if (m_valid && m_ready) begin
        if (first_pop < 0) first_pop = c;
        last_pop = c; n_pop++;
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL first_words_extra got %h exp none", m_data); end
        else begin
          exp = sb.pop_front();
          if ({m_last, m_data} !== exp) begin
            errors++; $display("FAIL first_words_word got last=%b data=%h exp last=%b data=%h", m_last, m_data, exp[8], exp[7:0]);
          end
        end
      end
      next_edge();
    end
    checks++; if (n_rr != 3) begin errors++; $display("FAIL first_words_nreq got %0d exp 3", n_rr); end
    checks++; if (last_rr - first_rr != 2) begin errors++; $display("FAIL first_words_req_span got %0d exp 2", last_rr - first_rr); end
    checks++; if (first_pop - first_rr != 2) begin errors++; $display("FAIL first_words_latency got %0d exp 2", first_pop - first_rr); end
    checks++; if (n_pop != 3 || last_pop - first_pop != 2) begin
      errors++; $display("FAIL first_words_pops got n=%0d span=%0d exp n=3 span=2", n_pop, last_pop - first_pop);
    end
    checks++; if (bad_rr != 0) begin errors++; $display("FAIL first_words_req_when_empty got %0d exp 0", bad_rr); end
  endtask

  task automatic test_burst_last();
    int n_pop = 0, n_last = 0, first_pop = -1, last_pop = -1, bad_rr = 0, n_uf = 0;
    logic [8:0] exp;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      fifo_put(8'(i)); sb_put(8'(i));
    end
    m_ready = 1'b1; enable = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (read_req && fifo_empty) bad_rr++;
      if (fifo_uf) n_uf++;
      if (m_valid && m_ready) begin
        if (first_pop < 0) first_pop = c;
        last_pop = c; n_pop++;
        if (m_last) n_last++;
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL burst_extra got %h exp none", m_data); end
        else begin
          exp = sb.pop_front();
          if ({m_last, m_data} !== exp) begin
            errors++; $display("FAIL burst_word got last=%b data=%h exp last=%b data=%h", m_last, m_data, exp[8], exp[7:0]);
          end
        end
      end
      next_edge();
    end
    checks++; if (n_last != 2) begin errors++; $display("FAIL burst_nlast got %0d exp 2", n_last); end
    checks++; if (n_pop != 8 || last_pop - first_pop != 7) begin
      errors++; $display("FAIL burst_throughput got n=%0d span=%0d exp n=8 span=7", n_pop, last_pop - first_pop);
    end
    checks++; if (bad_rr != 0 || n_uf != 0) begin
      errors++; $display("FAIL burst_underflow got bad_req=%0d uf=%0d exp 0 0", bad_rr, n_uf);
    end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL burst_err got %b exp 0", err); end
  endtask

  task automatic test_backpressure();
    int n_rr = 0, n_valid = 0, n_pop = 0;
    logic [8:0] exp;
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fifo_put(8'hA0 + 8'(i)); sb_put(8'hA0 + 8'(i));
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (read_req) n_rr++;
      if (m_valid) begin
        n_valid++;
        checks++;
        if (m_data !== 8'hA0) begin errors++; $display("FAIL bp_stable got %h exp a0", m_data); end
      end
      next_edge();
    end
    checks++; if (n_rr != 2) begin errors++; $display("FAIL bp_nreq got %0d exp 2", n_rr); end
    checks++; if (n_valid != 3) begin errors++; $display("FAIL bp_valid_cycles got %0d exp 3", n_valid); end
    m_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (m_valid && m_ready) begin
        n_pop++;
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL bp_extra got %h exp none", m_data); end
        else begin
          exp = sb.pop_front();
          if ({m_last, m_data} !== exp) begin
            errors++; $display("FAIL bp_word got last=%b data=%h exp last=%b data=%h", m_last, m_data, exp[8], exp[7:0]);
          end
        end
      end
      next_edge();
    end
    checks++; if (n_pop != 4) begin errors++; $display("FAIL bp_npop got %0d exp 4", n_pop); end
  endtask

  task automatic test_drain();
    int late_rr = 0, n_pop = 0, last_pop = -1, busy_low = -1, busy_gap = 0;
    logic [8:0] exp;
    m_ready = 1'b1;
    fifo_put(8'hB0); sb_put(8'hB0);
    fifo_put(8'hB1); sb_put(8'hB1);
    fifo_put(8'hB2);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c >= 2 && read_req) late_rr++;
      if (!busy && busy_low < 0) busy_low = c;
      if (busy && busy_low >= 0) busy_gap++;
      if (m_valid && m_ready) begin
        last_pop = c; n_pop++;
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL drain_extra got %h exp none", m_data); end
        else begin
          exp = sb.pop_front();
          if ({m_last, m_data} !== exp) begin
            errors++; $display("FAIL drain_word got last=%b data=%h exp last=%b data=%h", m_last, m_data, exp[8], exp[7:0]);
          end
        end
      end
      next_edge();
      if (c == 0) enable = 1'b0;
    end
    checks++; if (late_rr != 0) begin errors++; $display("FAIL drain_no_req got %0d exp 0", late_rr); end
    checks++; if (n_pop != 2) begin errors++; $display("FAIL drain_npop got %0d exp 2", n_pop); end
    checks++; if (busy_low - last_pop != 2 || busy_gap != 0) begin
      errors++; $display("FAIL drain_busy_fall got %0d exp 2", busy_low - last_pop);
    end
    checks++; if (fifo_empty !== 1'b0) begin errors++; $display("FAIL drain_word_left got empty=%b exp 0", fifo_empty); end
  endtask

  task automatic test_err_and_reset();
    int err_drops = 0, n_pop = 0;
    logic [8:0] exp;
    apply_reset();
    m_ready = 1'b1;
    @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_before got %b exp 0", err); end
    next_edge();
    inj_rdv = 1'b1; inj_data = 8'hE5; sb_put(8'hE5);
    next_edge();
    inj_rdv = 1'b0;
    @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", err); end
    for (int i = 0; i < 6; i++) begin
      if (err !== 1'b1) err_drops++;
      if (m_valid && m_ready) begin
        checks++;
        exp = sb.size() != 0 ? sb.pop_front() : 9'h1FF;
        if ({m_last, m_data} !== exp) begin
          errors++; $display("FAIL err_word got last=%b data=%h exp last=%b data=%h", m_last, m_data, exp[8], exp[7:0]);
        end
      end
      next_edge();
      @(negedge clk);
    end
    checks++; if (err_drops != 0) begin errors++; $display("FAIL err_sticky got drops=%0d exp 0", err_drops); end
    next_edge();
    for (int i = 0; i < 6; i++) begin
      fifo_put(8'hC0 + 8'(i)); sb_put(8'hC0 + 8'(i));
    end
    enable = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (m_valid && m_ready) begin
        checks++;
        exp = sb.size() != 0 ? sb.pop_front() : 9'h1FF;
        if ({m_last, m_data} !== exp) begin
          errors++; $display("FAIL midstream_word got last=%b data=%h exp last=%b data=%h", m_last, m_data, exp[8], exp[7:0]);
        end
      end
      next_edge();
    end
    rst = 1'b0;
    #1;
    checks++; if ({read_req, m_valid, m_last, busy, err} !== 5'b0 || m_data !== 8'h00) begin
      errors++; $display("FAIL async_reset got req=%b v=%b l=%b busy=%b err=%b data=%h exp all 0",
                         read_req, m_valid, m_last, busy, err, m_data);
    end
    enable = 1'b0; flush = 1'b1;
    next_edge();
    next_edge();
    flush = 1'b0;
    sb.delete();
    sb_idx = 0;
    rst = 1'b1;
    inj_rdv = 1'b1; inj_data = 8'h5A;
    next_edge();
    inj_rdv = 1'b0;
    @(negedge clk);
    checks++; if (err !== 1'b0 || m_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset_strobe got err=%b m_valid=%b exp 0 0", err, m_valid);
    end
    next_edge();
    for (int i = 0; i < 4; i++) begin
      fifo_put(8'hD0 + 8'(i)); sb_put(8'hD0 + 8'(i));
    end
    enable = 1'b1; m_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (m_valid && m_ready) begin
        n_pop++;
        checks++;
        exp = sb.size() != 0 ? sb.pop_front() : 9'h1FF;
        if ({m_last, m_data} !== exp) begin
          errors++; $display("FAIL resume_word got last=%b data=%h exp last=%b data=%h", m_last, m_data, exp[8], exp[7:0]);
        end
      end
      next_edge();
    end
    checks++; if (n_pop != 4 || err !== 1'b0) begin
      errors++; $display("FAIL resume_count got n=%0d err=%b exp 4 0", n_pop, err);
    end
  endtask

`ifdef FIFO_RD_STALL_CNT_EN
  task automatic test_stall_cnt();
    int seen = 0;
    apply_reset();
    fifo_put(8'hF0);
    m_ready = 1'b0; enable = 1'b1;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(negedge clk);
      if (m_valid) seen = 1;
      else next_edge();
    end
    checks++; if (seen == 0) begin errors++; $display("FAIL stall_wait_valid got timeout exp m_valid"); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL stall_start got %0d exp 0", stall_cnt); end
    for (int i = 0; i < 10; i++) begin
      next_edge();
      @(negedge clk);
    end
    checks++; if (stall_cnt !== 16'd10) begin errors++; $display("FAIL stall_count got %0d exp 10", stall_cnt); end
    next_edge();
    enable = 1'b0;
    next_edge();
    enable = 1'b1;
    next_edge();
    @(negedge clk);
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL stall_clear got %0d exp 0", stall_cnt); end
    next_edge();
    m_ready = 1'b1;
  endtask
`endif

  initial begin
    rst = 1'b0; enable = 1'b0; m_ready = 1'b0; flush = 1'b1;
    inj_rdv = 1'b0; inj_data = 8'h00; wp = 8'd0;
    test_reset();
    test_first_words();
    test_burst_last();
    test_backpressure();
    test_drain();
    test_err_and_reset();
`ifdef FIFO_RD_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
